// File: rtl/hist_pkg.sv
// Shared histogram-equalisation constants, load-state encoding and scaling helper.
// Also imported by the histogram builder for its median threshold.
package hist_pkg;

  localparam int unsigned BINS       = 256;
  localparam int unsigned BIN_W      = 8;
  localparam int unsigned CUM_W      = 20;
  localparam int unsigned PIX_W      = 12;
  localparam int unsigned EQ_W       = 8;
  localparam int unsigned TOTAL_PIX  = 384000;
  localparam int unsigned MEDIAN_THR = TOTAL_PIX / 2;
  localparam int unsigned SCALE_MUL  = 11142;
  localparam int unsigned SCALE_SH   = 24;
  localparam int unsigned PROD_W     = 36;
  localparam int unsigned CNT_W      = 9;
  localparam int unsigned CNT_MAX    = (1 << CNT_W) - 1;
  localparam int unsigned ST_W       = 2;

  typedef enum logic [ST_W-1:0] {
    LD_IDLE  = 2'd0,
    LD_FILL  = 2'd1,
    LD_DRAIN = 2'd2,
    LD_READY = 2'd3
  } ld_state_e;

  // Stage-1 payload of the cumulative-count scaler
  typedef struct packed {
    logic              wen;
    logic [BIN_W-1:0]  addr;
    logic [PROD_W-1:0] prod;
  } ld_stage_t;

  // Fixed-point product to 8-bit equalisation value, saturating at full scale
  function automatic logic [EQ_W-1:0] sat_scale(input logic [PROD_W-1:0] prod);
    logic [PROD_W-1:0] val;
    val = prod >> SCALE_SH;
    if (val > PROD_W'(255)) begin
      return {EQ_W{1'b1}};
    end
    return val[EQ_W-1:0];
  endfunction

endpackage

// File: rtl/hist_eq_mapper_if.sv
// Load and pixel bus of the equalisation mapper: table load, live pixels, status.
interface hist_eq_mapper_if;
  import hist_pkg::*;

  logic              iLd_Wen;
  logic [BIN_W-1:0]  iLd_Addr;
  logic [CUM_W-1:0]  iLd_Data;
  logic              iLd_Done;
  logic              iFval;
  logic              iDval;
  logic [PIX_W-1:0]  iGrey;
  logic [EQ_W-1:0]   oEq;
  logic              oEq_Dval;
  logic              oTblValid;
  logic              oBank;
  logic              oLoadErr;
  logic [ST_W-1:0]   oLdState;

  modport master (
    output iLd_Wen, iLd_Addr, iLd_Data, iLd_Done, iFval, iDval, iGrey,
    input  oEq, oEq_Dval, oTblValid, oBank, oLoadErr, oLdState
  );

  modport slave (
    input  iLd_Wen, iLd_Addr, iLd_Data, iLd_Done, iFval, iDval, iGrey,
    output oEq, oEq_Dval, oTblValid, oBank, oLoadErr, oLdState
  );

endinterface

// File: rtl/hist_eq_lut.sv
// Ping-pong equalisation LUT: two 256x8 banks, one write port to a chosen bank,
// one registered read port from the other; matches the simple dual-port macro.
module hist_eq_lut
  import hist_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic             wr_bank,
  input  logic [BIN_W-1:0] wr_addr,
  input  logic [EQ_W-1:0]  wr_data,
  input  logic             rd_bank,
  input  logic [BIN_W-1:0] rd_addr,
  output logic [EQ_W-1:0]  rd_data
);

  logic [EQ_W-1:0] bank0_mem [BINS];
  logic [EQ_W-1:0] bank1_mem [BINS];
  logic [EQ_W-1:0] rd_data_q, rd_data_d;

  // Storage is not reset; a table is only read once it has been fully loaded
  always_ff @(posedge clk) begin
    if (wr_en && !wr_bank) begin
      bank0_mem[wr_addr] <= wr_data;
    end
    if (wr_en && wr_bank) begin
      bank1_mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data_d = rd_bank ? bank1_mem[rd_addr] : bank0_mem[rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/hist_eq_mapper.sv
// Histogram-equalisation mapper: scales cumulative counts into the inactive LUT bank
// during blanking, swaps banks at frame start and maps live grey pixels through it.
module hist_eq_mapper
  import hist_pkg::*;
(
  input  logic            iPclk,
  input  logic            iRst_n,
  hist_eq_mapper_if.slave bus
);

  ld_stage_t        ld_q, ld_d;
  ld_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             drain_q, drain_d;
  logic             bank_q, bank_d;
  logic             tbl_valid_q, tbl_valid_d;
  logic             load_err_q, load_err_d;
  logic             fval_prev_q, fval_prev_d;
  logic             fval_rise;

  logic [BIN_W-1:0] bin_q, bin_d;
  logic             pix_dv_q, pix_dv_d;
  logic             bypass_q, bypass_d;
  logic [EQ_W-1:0]  eq_q, eq_d;
  logic             eq_dval_q, eq_dval_d;

  logic [BIN_W-1:0] grey_bin;
  logic [EQ_W-1:0]  lut_wr_data;
  logic [EQ_W-1:0]  lut_rd_data;
  logic             unused_grey_lsb;

  assign grey_bin        = bus.iGrey[PIX_W-1 -: BIN_W];
  assign unused_grey_lsb = ^bus.iGrey[PIX_W-BIN_W-1:0];
  assign fval_rise       = bus.iFval && !fval_prev_q;

  // Scaler stage 1: entries arriving while draining are dropped
  always_comb begin
    ld_d      = '0;
    ld_d.wen  = bus.iLd_Wen && (state_q != LD_DRAIN);
    ld_d.addr = bus.iLd_Addr;
    ld_d.prod = PROD_W'(bus.iLd_Data) * PROD_W'(SCALE_MUL);
  end

  // Scaler stage 2 saturates and writes the bank not being displayed
  assign lut_wr_data = sat_scale(ld_q.prod);

  hist_eq_lut u_lut (
    .clk     (iPclk),
    .rst_n   (iRst_n),
    .wr_en   (ld_q.wen),
    .wr_bank (~bank_q),
    .wr_addr (ld_q.addr),
    .wr_data (lut_wr_data),
    .rd_bank (bank_q),
    .rd_addr (grey_bin),
    .rd_data (lut_rd_data)
  );

  // Load FSM: a write is counted before a coincident Done is judged
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    drain_d     = drain_q;
    bank_d      = bank_q;
    tbl_valid_d = tbl_valid_q;
    load_err_d  = load_err_q;
    fval_prev_d = bus.iFval;
    cnt_inc     = (cnt_q == CNT_W'(CNT_MAX)) ? cnt_q : cnt_q + CNT_W'(1);

    unique case (state_q)
      LD_IDLE, LD_FILL, LD_READY: begin
        if (bus.iLd_Wen) begin
          state_d = LD_FILL;
          cnt_d   = (state_q == LD_FILL) ? cnt_inc : CNT_W'(1);
        end else if ((state_q == LD_READY) && fval_rise) begin
          bank_d      = ~bank_q;
          tbl_valid_d = 1'b1;
          state_d     = LD_IDLE;
          cnt_d       = '0;
        end
        if (bus.iLd_Done && ((state_q != LD_READY) || bus.iLd_Wen)) begin
          if (cnt_d == CNT_W'(BINS)) begin
            state_d    = LD_DRAIN;
            drain_d    = 1'b0;
            load_err_d = 1'b0;
          end else begin
            state_d    = LD_IDLE;
            load_err_d = 1'b1;
            cnt_d      = '0;
          end
        end
      end
      LD_DRAIN: begin
        if (bus.iLd_Wen) begin
          state_d    = LD_IDLE;
          load_err_d = 1'b1;
          cnt_d      = '0;
        end else if (drain_q) begin
          state_d = LD_READY;
        end else begin
          drain_d = 1'b1;
        end
      end
    endcase
  end

  // Pixel path: bin/bank/valid in cycle 1, LUT result or bypass into oEq in cycle 2
  always_comb begin
    bin_d     = grey_bin;
    pix_dv_d  = bus.iDval && bus.iFval;
    bypass_d  = !tbl_valid_q;
    eq_d      = eq_q;
    eq_dval_d = pix_dv_q;
    if (pix_dv_q) begin
      eq_d = bypass_q ? bin_q : lut_rd_data;
    end
  end

  always_ff @(posedge iPclk or negedge iRst_n) begin
    if (!iRst_n) begin
      ld_q        <= '0;
      state_q     <= LD_IDLE;
      cnt_q       <= '0;
      drain_q     <= 1'b0;
      bank_q      <= 1'b0;
      tbl_valid_q <= 1'b0;
      load_err_q  <= 1'b0;
      fval_prev_q <= 1'b0;
      bin_q       <= '0;
      pix_dv_q    <= 1'b0;
      bypass_q    <= 1'b1;
      eq_q        <= '0;
      eq_dval_q   <= 1'b0;
    end else begin
      ld_q        <= ld_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      drain_q     <= drain_d;
      bank_q      <= bank_d;
      tbl_valid_q <= tbl_valid_d;
      load_err_q  <= load_err_d;
      fval_prev_q <= fval_prev_d;
      bin_q       <= bin_d;
      pix_dv_q    <= pix_dv_d;
      bypass_q    <= bypass_d;
      eq_q        <= eq_d;
      eq_dval_q   <= eq_dval_d;
    end
  end

  assign bus.oEq       = eq_q;
  assign bus.oEq_Dval  = eq_dval_q;
  assign bus.oTblValid = tbl_valid_q;
  assign bus.oBank     = bank_q;
  assign bus.oLoadErr  = load_err_q;
  assign bus.oLdState  = state_q;

endmodule

// File: tb/tb_hist_eq_mapper.sv
// Self-checking bench for hist_eq_mapper against a table-level reference model.
module tb_hist_eq_mapper;
  import hist_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hist_eq_mapper_if bus ();
  hist_eq_mapper dut (.iPclk(clk), .iRst_n(rst_n), .bus(bus));

  int checks = 0;
  int failures = 0;

  // Reference: contents of both banks, which one is displayed, and the held output
  logic [7:0] model_mem [2][256];
  int         model_bank;
  bit         model_valid;
  logic [7:0] model_eq;

  function automatic logic [7:0] ref_scale(input int unsigned cum);
    longint unsigned v;
    v = (longint'(cum) * 64'd11142) / 64'd16777216;
    return (v > 64'd255) ? 8'd255 : 8'(v);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_done();
    bus.iLd_Done = 1'b1;
    step();
    bus.iLd_Done = 1'b0;
  endtask

  task automatic load_table(input int n, input bit linear, input int sat_idx);
    int unsigned d;
    for (int k = 0; k < n; k++) begin
      d = linear ? 32'((k + 1) * 1500) : $urandom_range(0, 400000);
      if (k == sat_idx) d = 32'h000F_FFFF;
      bus.iLd_Wen  = 1'b1;
      bus.iLd_Addr = 8'(k);
      bus.iLd_Data = 20'(d);
      model_mem[1 - model_bank][k] = ref_scale(d);
      step();
    end
    bus.iLd_Wen = 1'b0;
  endtask

  task automatic send_pixel(input logic [11:0] g, output logic [7:0] eq, output logic dv);
    bus.iDval = 1'b1;
    bus.iGrey = g;
    step();
    bus.iDval = 1'b0;
    step();
    eq = bus.oEq;
    dv = bus.oEq_Dval;
  endtask

  // Random pixel stream with iFval held high; checks every output cycle
  task automatic run_pixels(input int n);
    logic [8:0]  q[$];
    logic [8:0]  e;
    logic [11:0] g;
    bit          dv;
    for (int i = 0; i < n + 2; i++) begin
      dv = (i < n) ? ($urandom_range(0, 3) != 0) : 1'b0;
      g  = 12'($urandom);
      bus.iDval = dv;
      bus.iGrey = g;
      q.push_back({dv, model_valid ? model_mem[model_bank][g[11:4]] : g[11:4]});
      step();
      if (q.size() == 2) begin
        e = q.pop_front();
        if (e[8]) model_eq = e[7:0];
        checks++;
        if (bus.oEq_Dval !== e[8] || bus.oEq !== model_eq) begin
          failures++;
          $display("FAIL pixel_stream: oEq=%h oEq_Dval=%b expected oEq=%h oEq_Dval=%b",
                   bus.oEq, bus.oEq_Dval, model_eq, e[8]);
        end
      end
    end
    bus.iDval = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.iLd_Wen = 0; bus.iLd_Addr = 0; bus.iLd_Data = 0; bus.iLd_Done = 0;
    bus.iFval = 0; bus.iDval = 0; bus.iGrey = 0;
    model_bank = 0; model_valid = 0; model_eq = 8'd0;
    repeat (3) step();
    checks++;
    if (bus.oEq !== 8'd0 || bus.oEq_Dval !== 1'b0 || bus.oTblValid !== 1'b0 ||
        bus.oBank !== 1'b0 || bus.oLoadErr !== 1'b0 || bus.oLdState !== 2'd0) begin
      failures++;
      $display("FAIL reset_values: eq=%h dv=%b tv=%b bank=%b err=%b st=%0d expected all 0",
               bus.oEq, bus.oEq_Dval, bus.oTblValid, bus.oBank, bus.oLoadErr, bus.oLdState);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_bypass();
    logic [7:0] eq; logic dv;
    bus.iFval = 1'b1;
    step();
    send_pixel(12'hAB0, eq, dv);
    checks++;
    if (eq !== 8'hAB || dv !== 1'b1 || bus.oTblValid !== 1'b0) begin
      failures++;
      $display("FAIL bypass_ab0: oEq=%h dv=%b tv=%b expected oEq=ab dv=1 tv=0", eq, dv, bus.oTblValid);
    end
    model_eq = 8'hAB;
    step();
    checks++;
    if (bus.oEq_Dval !== 1'b0 || bus.oEq !== 8'hAB) begin
      failures++;
      $display("FAIL bypass_hold: oEq=%h dv=%b expected oEq=ab dv=0", bus.oEq, bus.oEq_Dval);
    end
    run_pixels(40);
    bus.iFval = 1'b0;
    step();
  endtask

  task automatic test_full_load();
    logic [7:0] eq; logic dv;
    load_table(256, 1'b1, -1);
    pulse_done();
    step();
    checks++;
    if (bus.oLdState !== 2'd2) begin
      failures++;
      $display("FAIL full_drain: state=%0d expected 2", bus.oLdState);
    end
    step();
    checks++;
    if (bus.oLdState !== 2'd3 || bus.oLoadErr !== 1'b0) begin
      failures++;
      $display("FAIL full_ready: state=%0d err=%b expected state=3 err=0", bus.oLdState, bus.oLoadErr);
    end
    bus.iFval = 1'b1;
    step();
    model_bank = 1 - model_bank; model_valid = 1'b1;
    checks++;
    if (bus.oBank !== 1'b1 || bus.oTblValid !== 1'b1 || bus.oLdState !== 2'd0) begin
      failures++;
      $display("FAIL full_swap: bank=%b tv=%b st=%0d expected bank=1 tv=1 st=0",
               bus.oBank, bus.oTblValid, bus.oLdState);
    end
    send_pixel(12'h000, eq, dv);
    checks++;
    if (eq !== 8'd0 || dv !== 1'b1) begin
      failures++;
      $display("FAIL eq_000: oEq=%0d dv=%b expected 0 dv=1", eq, dv);
    end
    send_pixel(12'h7F0, eq, dv);
    checks++;
    if (eq !== 8'd127 || dv !== 1'b1) begin
      failures++;
      $display("FAIL eq_7f0: oEq=%0d dv=%b expected 127 dv=1", eq, dv);
    end
    send_pixel(12'hFF0, eq, dv);
    checks++;
    if (eq !== 8'd255 || dv !== 1'b1) begin
      failures++;
      $display("FAIL eq_ff0: oEq=%0d dv=%b expected 255 dv=1", eq, dv);
    end
    model_eq = 8'd255;
    run_pixels(60);
    bus.iFval = 1'b0;
    step();
  endtask

  task automatic test_short_load();
    load_table(255, 1'b0, -1);
    pulse_done();
    checks++;
    if (bus.oLoadErr !== 1'b1 || bus.oLdState !== 2'd0) begin
      failures++;
      $display("FAIL short_err: err=%b st=%0d expected err=1 st=0", bus.oLoadErr, bus.oLdState);
    end
    bus.iFval = 1'b1;
    step();
    checks++;
    if (bus.oBank !== 1'(model_bank) || bus.oTblValid !== 1'b1) begin
      failures++;
      $display("FAIL short_noswap: bank=%b tv=%b expected bank=%0d tv=1", bus.oBank, bus.oTblValid, model_bank);
    end
    run_pixels(30);
    bus.iFval = 1'b0;
    step();
  endtask

  task automatic test_saturation_abandon();
    logic [7:0] eq; logic dv;
    load_table(256, 1'b0, -1);
    pulse_done();
    repeat (2) step();
    bus.iLd_Wen = 1'b1; bus.iLd_Addr = 8'd5; bus.iLd_Data = 20'($urandom_range(0, 400000));
    model_mem[1 - model_bank][5] = ref_scale(32'(bus.iLd_Data));
    step();
    bus.iLd_Wen = 1'b0;
    checks++;
    if (bus.oLdState !== 2'd1) begin
      failures++;
      $display("FAIL abandon_fill: st=%0d expected 1", bus.oLdState);
    end
    bus.iFval = 1'b1;
    step();
    checks++;
    if (bus.oBank !== 1'(model_bank) || bus.oLdState !== 2'd1) begin
      failures++;
      $display("FAIL abandon_noswap: bank=%b st=%0d expected bank=%0d st=1", bus.oBank, bus.oLdState, model_bank);
    end
    bus.iFval = 1'b0;
    step();
    pulse_done();
    checks++;
    if (bus.oLoadErr !== 1'b1 || bus.oLdState !== 2'd0) begin
      failures++;
      $display("FAIL abandon_done: err=%b st=%0d expected err=1 st=0", bus.oLoadErr, bus.oLdState);
    end
    load_table(256, 1'b0, 8'h5A);
    pulse_done();
    repeat (2) step();
    bus.iFval = 1'b1;
    step();
    model_bank = 1 - model_bank;
    checks++;
    if (bus.oBank !== 1'(model_bank) || bus.oLoadErr !== 1'b0) begin
      failures++;
      $display("FAIL sat_swap: bank=%b err=%b expected bank=%0d err=0", bus.oBank, bus.oLoadErr, model_bank);
    end
    send_pixel(12'h5A0, eq, dv);
    checks++;
    if (eq !== 8'd255 || dv !== 1'b1) begin
      failures++;
      $display("FAIL sat_value: oEq=%0d dv=%b expected 255 dv=1", eq, dv);
    end
    model_eq = 8'd255;
    run_pixels(40);
    bus.iFval = 1'b0;
    step();
  endtask

  task automatic test_midframe_load();
    bus.iFval = 1'b1;
    step();
    fork
      load_table(256, 1'b0, -1);
      run_pixels(300);
    join
    pulse_done();
    repeat (2) step();
    checks++;
    if (bus.oLdState !== 2'd3 || bus.oBank !== 1'(model_bank)) begin
      failures++;
      $display("FAIL midframe_ready: st=%0d bank=%b expected st=3 bank=%0d", bus.oLdState, bus.oBank, model_bank);
    end
    run_pixels(20);
    bus.iFval = 1'b0;
    step();
    bus.iFval = 1'b1;
    step();
    model_bank = 1 - model_bank;
    checks++;
    if (bus.oBank !== 1'(model_bank) || bus.oLdState !== 2'd0) begin
      failures++;
      $display("FAIL midframe_swap: bank=%b st=%0d expected bank=%0d st=0", bus.oBank, bus.oLdState, model_bank);
    end
    run_pixels(40);
    bus.iFval = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_fill();
    bus.iFval = 1'b1;
    step();
    bus.iDval = 1'b1;
    bus.iGrey = 12'hFF0;
    load_table(100, 1'b0, -1);
    checks++;
    if (bus.oLdState !== 2'd1 || bus.oEq_Dval !== 1'b1 || bus.oTblValid !== 1'b1) begin
      failures++;
      $display("FAIL prereset: st=%0d dv=%b tv=%b expected st=1 dv=1 tv=1",
               bus.oLdState, bus.oEq_Dval, bus.oTblValid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.oEq !== 8'd0 || bus.oEq_Dval !== 1'b0 || bus.oTblValid !== 1'b0 ||
        bus.oBank !== 1'b0 || bus.oLoadErr !== 1'b0 || bus.oLdState !== 2'd0) begin
      failures++;
      $display("FAIL async_reset: eq=%h dv=%b tv=%b bank=%b err=%b st=%0d expected all 0",
               bus.oEq, bus.oEq_Dval, bus.oTblValid, bus.oBank, bus.oLoadErr, bus.oLdState);
    end
    bus.iDval = 1'b0; bus.iFval = 1'b0; bus.iLd_Wen = 1'b0;
    model_bank = 0; model_valid = 1'b0; model_eq = 8'd0;
    step();
    rst_n = 1'b1;
    step();
    bus.iFval = 1'b1;
    step();
    checks++;
    if (bus.oTblValid !== 1'b0 || bus.oBank !== 1'b0 || bus.oLdState !== 2'd0) begin
      failures++;
      $display("FAIL post_reset_frame: tv=%b bank=%b st=%0d expected 0 0 0",
               bus.oTblValid, bus.oBank, bus.oLdState);
    end
    run_pixels(30);
    bus.iFval = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_full_load();
    test_short_load();
    test_saturation_abandon();
    test_midframe_load();
    test_reset_mid_fill();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
